// File: rtl/quad_decoder_array.sv
// Multi-channel quadrature decoder. Each channel synchronises, filters and decodes its phase pair
// into an x1/x2/x4 up/down count. Registers are reached over a shared tri-state CPU bus.
module quad_decoder_array #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 32,
  parameter int FILTER_LEN = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            oe,
  input  logic                            we,
  input  logic [$clog2(CHANNELS)+2-1:0]   addr,
  input  logic [CHANNELS-1:0]             ext_phase_a,
  input  logic [CHANNELS-1:0]             ext_phase_b,
  inout  wire  [WIDTH-1:0]                data,
  output logic                            irq
);

  localparam int AW = $clog2(CHANNELS) + 2;
  localparam int RW = $clog2(FILTER_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN);
  localparam logic [AW-1:0] CH_LIM  = AW'(CHANNELS);

  localparam logic [1:0] REG_COUNT  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // Bus protocol: a write is captured on the rising edge whenever we=1 (oe is ignored);
  // the DUT drives data combinationally only while oe=1 and we=0, otherwise it floats.

  logic [1:0]       sync1     [CHANNELS];
  logic [1:0]       sync2     [CHANNELS];
  logic [1:0]       cand      [CHANNELS];
  logic [1:0]       filt      [CHANNELS];
  logic [1:0]       filt_prev [CHANNELS];
  logic [RW-1:0]    run       [CHANNELS];
  logic [RW-1:0]    run_next  [CHANNELS];
  logic [WIDTH-1:0] count     [CHANNELS];
  logic [2:0]       flags     [CHANNELS];
  logic [1:0]       mode      [CHANNELS];

  logic [CHANNELS-1:0] primed, upd, en, dir;
  logic [CHANNELS-1:0] accept, cnt_ev, cnt_up, ill_ev, ovf_set, unf_set;
  logic [CHANNELS-1:0] wr_count, wr_status, wr_ctrl;

  logic [AW-1:0]    ch_sel;
  logic             sel_ok;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_data;

  assign ch_sel = addr >> 2;
  assign sel_ok = (ch_sel < CH_LIM);
  assign wdata  = data;
  assign data   = (oe && !we) ? rd_data : {WIDTH{1'bz}};

  always_comb begin
    logic [1:0] chg;
    logic       a_edge, b_edge, step, up_v;
    chg    = '0;
    a_edge = 1'b0;
    b_edge = 1'b0;
    step   = 1'b0;
    up_v   = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_count[i]  = we && sel_ok && (ch_sel == AW'(i)) && (addr[1:0] == REG_COUNT);
      wr_status[i] = we && sel_ok && (ch_sel == AW'(i)) && (addr[1:0] == REG_STATUS);
      wr_ctrl[i]   = we && sel_ok && (ch_sel == AW'(i)) && (addr[1:0] == REG_CTRL);

      if (sync2[i] == cand[i])
        run_next[i] = (run[i] == RUN_MAX) ? run[i] : run[i] + 1'b1;
      else
        run_next[i] = RW'(1);
      accept[i] = (run_next[i] == RUN_MAX);

      chg    = filt_prev[i] ^ filt[i];
      a_edge = (chg == 2'b10);
      b_edge = (chg == 2'b01);
      // For a single-phase change the new state alone fixes direction:
      // an A edge is forward when A==B afterwards, a B edge when A!=B afterwards.
      case (mode[i])
        2'b10: begin
          step = a_edge || b_edge;
          up_v = a_edge ? (filt[i][1] == filt[i][0]) : (filt[i][1] != filt[i][0]);
        end
        2'b01: begin
          step = a_edge && filt[i][1];
          up_v = filt[i][0];
        end
        default: begin
          step = a_edge;
          up_v = (filt[i][1] == filt[i][0]);
        end
      endcase

      cnt_ev[i]  = upd[i] && en[i] && step && !wr_count[i];
      cnt_up[i]  = up_v;
      ill_ev[i]  = upd[i] && en[i] && (chg == 2'b11);
      ovf_set[i] = cnt_ev[i] && up_v && (count[i] == {WIDTH{1'b1}});
      unf_set[i] = cnt_ev[i] && !up_v && (count[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync1[i]     <= '0;
        sync2[i]     <= '0;
        cand[i]      <= '0;
        filt[i]      <= '0;
        filt_prev[i] <= '0;
        run[i]       <= '0;
        count[i]     <= '0;
        flags[i]     <= '0;
        mode[i]      <= 2'b00;
        primed[i]    <= 1'b0;
        upd[i]       <= 1'b0;
        en[i]        <= 1'b1;
        dir[i]       <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync1[i] <= {ext_phase_a[i], ext_phase_b[i]};
        sync2[i] <= sync1[i];
        cand[i]  <= sync2[i];
        run[i]   <= run_next[i];
        upd[i]   <= 1'b0;
        // The first accepted value after reset only establishes the reference state.
        if (accept[i] && !primed[i]) begin
          filt[i]      <= sync2[i];
          filt_prev[i] <= sync2[i];
          primed[i]    <= 1'b1;
        end else if (accept[i] && (sync2[i] != filt[i])) begin
          filt_prev[i] <= filt[i];
          filt[i]      <= sync2[i];
          upd[i]       <= 1'b1;
        end

        if (wr_count[i])
          count[i] <= wdata;
        else if (cnt_ev[i])
          count[i] <= cnt_up[i] ? count[i] + 1'b1 : count[i] - 1'b1;

        if (cnt_ev[i])
          dir[i] <= cnt_up[i];

        flags[i] <= (flags[i] & ~(wr_status[i] ? wdata[2:0] : 3'b000))
                  | {unf_set[i], ovf_set[i], ill_ev[i]};

        if (wr_ctrl[i]) begin
          mode[i] <= wdata[1:0];
          en[i]   <= wdata[2];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    irq     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      irq = irq | (en[i] && (flags[i] != 3'b000));
      if (sel_ok && (ch_sel == AW'(i))) begin
        case (addr[1:0])
          REG_COUNT:  rd_data = count[i];
          REG_STATUS: rd_data = {{(WIDTH-4){1'b0}}, dir[i], flags[i]};
          REG_CTRL:   rd_data = {{(WIDTH-3){1'b0}}, en[i], mode[i]};
          default:    rd_data = '0;
        endcase
      end
    end
  end

endmodule
